// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 mux bank.
// Ownership lasts one packet (ended by last_x) or until the optional hold limit forces a hand-over.
module mux2_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic last_a,
  input  logic req_b,
  input  logic last_b,
  input  logic out_ready,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic out_valid,
  output logic out_last,
  output logic busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam bit HOLD_EN = (MAX_HOLD != 0);
  // With no hold limit the counter simply saturates at all-ones and is never compared.
  localparam logic [CNT_W-1:0] HOLD_TOP = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '1;

  logic [1:0]       state_reg, state_next;
  logic             last_owner_reg, last_owner_next;   // 1 = B owned last
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             sel_reg, gnt_a_reg, gnt_b_reg;

  logic own_is_b, own_last, other_req, accept;

  function automatic logic [1:0] arb(input logic lo_b, input logic ra, input logic rb);
    logic [1:0] res;
    res = IDLE;
    if (ra && rb)
      res = lo_b ? OWN_A : OWN_B;
    else if (ra)
      res = OWN_A;
    else if (rb)
      res = OWN_B;
    return res;
  endfunction

  assign out_valid = (gnt_a_reg & req_a) | (gnt_b_reg & req_b);
  assign out_last  = out_valid & ((gnt_a_reg & last_a) | (gnt_b_reg & last_b));
  assign busy      = (state_reg != IDLE);
  assign sel       = sel_reg;
  assign gnt_a     = gnt_a_reg;
  assign gnt_b     = gnt_b_reg;

  assign own_is_b  = (state_reg == OWN_B);
  assign own_last  = own_is_b ? last_b : last_a;
  assign other_req = own_is_b ? req_a : req_b;
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: state_next = arb(last_owner_reg, req_a, req_b);
      OWN_A, OWN_B: begin
        if (accept) begin
          if (own_last) begin
            last_owner_next = own_is_b;
            beat_cnt_next   = '0;
            state_next      = arb(own_is_b, req_a, req_b);
          end else if (HOLD_EN && (beat_cnt_reg == HOLD_TOP) && other_req) begin
            // Hold limit reached while the other side waits: hand over mid-packet.
            last_owner_next = own_is_b;
            beat_cnt_next   = '0;
            state_next      = own_is_b ? OWN_A : OWN_B;
          end else if (beat_cnt_reg != HOLD_TOP) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      beat_cnt_reg   <= '0;
      sel_reg        <= 1'b0;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      sel_reg        <= (state_next == OWN_B);
      gnt_a_reg      <= (state_next == OWN_A);
      gnt_b_reg      <= (state_next == OWN_B);
    end
  end

endmodule
